// File: rtl/barrel_shift_issue_if.sv
// barrel_shift_issue_if
// Command (in_*) and result (out_*) handshakes of barrel_shift_issue.
// The slave modport is the shifter-issue block; the master modport is
// whatever feeds commands and consumes results.
interface barrel_shift_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shift_issue.sv
// barrel_shift_issue
// Buffers {operand, amount} commands in a small FIFO, presents the head to
// an external combinational shifter, and registers the shifter result into
// a valid/ready output stage. One command can be issued per cycle.
// Optional feature: define BSHIFT_AMT_WRAP_EN to reduce the amount driven
// to the shifter modulo WIDTH; ports and timing are identical either way.
module barrel_shift_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    barrel_shift_issue_if.slave    bus,
    output logic [WIDTH-1:0]       sh_data,
    output logic [7:0]             sh_amt,
    input  logic [WIDTH-1:0]       sh_result,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [7:0]       fifo_amt  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             issue;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] head_data;
    logic [7:0]       head_amt;

    // Full is judged on the registered level only, so a pop in the same
    // cycle never lets a command in while the FIFO is full.
    assign not_full  = (count != FULL_LEVEL);
    assign not_empty = (count != '0);
    assign push      = bus.in_valid && not_full;
    assign issue     = not_empty && (!out_valid_q || bus.out_ready);

    // Head is forced to zero when nothing is queued so the shifter sees
    // a quiet operand instead of a stale entry.
    assign head_data = not_empty ? fifo_data[rd_ptr] : '0;
    assign head_amt  = not_empty ? fifo_amt[rd_ptr]  : '0;

    assign sh_data = head_data;

`ifdef BSHIFT_AMT_WRAP_EN
    localparam logic [7:0] AMT_MOD = 8'(WIDTH);
    assign sh_amt = head_amt % AMT_MOD;
`else
    assign sh_amt = head_amt;
`endif

    assign bus.in_ready  = not_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign level         = count;

    // FIFO storage: written on every accepted command; never reset because
    // the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.in_data;
            fifo_amt[wr_ptr]  <= bus.in_amt;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so the pointers wrap
    // naturally, and a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage: capture the shifter result on issue, drop valid once the
    // consumer takes it with nothing new behind, otherwise hold steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sh_result;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_barrel_shift_issue.sv
// tb_barrel_shift_issue
// Directed bench for barrel_shift_issue at WIDTH 8, 16 and 32. Each DUT is
// paired with a left-shift model acting as the downstream shifter.
// Expected results are hand-computed constants.
module tb_barrel_shift_issue;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    barrel_shift_issue_if #(.WIDTH(8))  bus8 ();
    barrel_shift_issue_if #(.WIDTH(16)) bus16 ();
    barrel_shift_issue_if #(.WIDTH(32)) bus32 ();

    logic [7:0]  sh_data8,  sh_result8;
    logic [7:0]  sh_amt8;
    logic [2:0]  level8;
    logic [15:0] sh_data16, sh_result16;
    logic [7:0]  sh_amt16;
    logic [2:0]  level16;
    logic [31:0] sh_data32, sh_result32;
    logic [7:0]  sh_amt32;
    logic [2:0]  level32;

    assign sh_result8  = sh_data8  << sh_amt8;
    assign sh_result16 = sh_data16 << sh_amt16;
    assign sh_result32 = sh_data32 << sh_amt32;

    barrel_shift_issue #(.WIDTH(8), .DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8),
        .sh_data(sh_data8), .sh_amt(sh_amt8), .sh_result(sh_result8), .level(level8)
    );

    barrel_shift_issue #(.WIDTH(16), .DEPTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16),
        .sh_data(sh_data16), .sh_amt(sh_amt16), .sh_result(sh_result16), .level(level16)
    );

    barrel_shift_issue #(.WIDTH(32), .DEPTH(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32),
        .sh_data(sh_data32), .sh_amt(sh_amt32), .sh_result(sh_result32), .level(level32)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  amt;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [16];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] stim_data [$];
    logic [7:0]  stim_amt  [$];
    logic [31:0] exp_res   [$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams the queued commands into the 32-bit DUT with out_ready high,
    // scoring results in order and flagging any gap once results start.
    task automatic apply_stimulus(input string tag, input int max_cycles);
        int send = 0;
        int recv = 0;
        int cyc  = 0;
        int n_in;
        int n_out;
        n_in  = stim_data.size();
        n_out = exp_res.size();
        bus32.out_ready = 1'b1;
        while ((send < n_in || recv < n_out) && cyc < max_cycles) begin
            if (send < n_in) begin
                bus32.in_valid = 1'b1;
                bus32.in_data  = stim_data[send];
                bus32.in_amt   = stim_amt[send];
            end else begin
                bus32.in_valid = 1'b0;
            end
            if (bus32.out_valid) begin
                if (recv < n_out) begin
                    check_output($sformatf("%s_result%0d", tag, recv), bus32.out_data, exp_res[recv]);
                end else begin
                    check_output({tag, "_extra_result"}, 32'(bus32.out_valid), 32'd0);
                end
                recv++;
            end else if (recv > 0 && recv < n_out) begin
                check_output({tag, "_no_gap"}, 32'(bus32.out_valid), 32'd1);
            end
            if (bus32.in_valid && bus32.in_ready) begin
                send++;
            end
            step();
            cyc++;
        end
        bus32.in_valid = 1'b0;
        check_output({tag, "_delivered"}, 32'(recv), 32'(n_out));
        stim_data.delete();
        stim_amt.delete();
        exp_res.delete();
    endtask

    initial begin
        logic [7:0]  exp_amt16;
        logic [15:0] exp_res16;

        vecs[0]  = '{32'h1234_5678, 8'd1,  32'h2468_ACF0};
        vecs[1]  = '{32'hFFFF_FFFF, 8'd2,  32'hFFFF_FFFC};
        vecs[2]  = '{32'h0000_0001, 8'd3,  32'h0000_0008};
        vecs[3]  = '{32'hABCD_EF01, 8'd4,  32'hBCDE_F010};
        vecs[4]  = '{32'h0000_0003, 8'd5,  32'h0000_0060};
        vecs[5]  = '{32'h8000_0000, 8'd6,  32'h0000_0000};
        vecs[6]  = '{32'h0000_00FF, 8'd7,  32'h0000_7F80};
        vecs[7]  = '{32'hDEAD_BEEF, 8'd8,  32'hADBE_EF00};
        vecs[8]  = '{32'h0000_0001, 8'd9,  32'h0000_0200};
        vecs[9]  = '{32'h0000_0005, 8'd10, 32'h0000_1400};
        vecs[10] = '{32'h0010_0000, 8'd11, 32'h8000_0000};
        vecs[11] = '{32'h0ABC_DEF0, 8'd12, 32'hCDEF_0000};
        vecs[12] = '{32'h0000_0007, 8'd13, 32'h0000_E000};
        vecs[13] = '{32'h0000_FFFF, 8'd14, 32'h3FFF_C000};
        vecs[14] = '{32'h0000_0002, 8'd15, 32'h0001_0000};
        vecs[15] = '{32'h1234_5678, 8'd16, 32'h5678_0000};

        rst_n = 1'b0;
        bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.in_amt  = '0; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_amt = '0; bus16.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_amt = '0; bus32.out_ready = 1'b0;

        // Reset state, checked while reset is held
        step();
        check_output("rst_in_ready32", 32'(bus32.in_ready), 32'd1);
        check_output("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
        check_output("rst_level32", 32'(level32), 32'd0);
        check_output("rst_out_valid32", 32'(bus32.out_valid), 32'd0);
        check_output("rst_out_data32", bus32.out_data, 32'd0);
        check_output("rst_sh_data32", sh_data32, 32'd0);
        check_output("rst_sh_amt32", 32'(sh_amt32), 32'd0);
        step();
        rst_n = 1'b1;
        check_output("post_rst_in_ready32", 32'(bus32.in_ready), 32'd1);

        // WIDTH=8 latency: push 8'h23 by 3 into an empty FIFO
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.in_data   = 8'h23;
        bus8.in_amt    = 8'd3;
        step();
        bus8.in_valid = 1'b0;
        check_output("u8_level_after_push", 32'(level8), 32'd1);
        check_output("u8_sh_data_head", 32'(sh_data8), 32'h23);
        check_output("u8_sh_amt_head", 32'(sh_amt8), 32'd3);
        check_output("u8_valid_after_push", 32'(bus8.out_valid), 32'd0);
        step();
        check_output("u8_valid_next_edge", 32'(bus8.out_valid), 32'd1);
        check_output("u8_out_data", 32'(bus8.out_data), 32'h18);
        check_output("u8_level_after_issue", 32'(level8), 32'd0);
        check_output("u8_sh_data_empty", 32'(sh_data8), 32'd0);
        step();
        check_output("u8_valid_cleared", 32'(bus8.out_valid), 32'd0);

        // WIDTH=16 amount handling: 20 wraps to 4 only with the macro
`ifdef BSHIFT_AMT_WRAP_EN
        exp_amt16 = 8'd4;
        exp_res16 = 16'h0010;
`else
        exp_amt16 = 8'd20;
        exp_res16 = 16'h0000;
`endif
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.in_data   = 16'h0001;
        bus16.in_amt    = 8'd20;
        step();
        bus16.in_valid = 1'b0;
        check_output("u16_sh_amt_20", 32'(sh_amt16), 32'(exp_amt16));
        step();
        check_output("u16_valid_amt20", 32'(bus16.out_valid), 32'd1);
        check_output("u16_result_amt20", 32'(bus16.out_data), 32'(exp_res16));
        bus16.in_valid = 1'b1;
        bus16.in_data  = 16'h00F0;
        bus16.in_amt   = 8'd5;
        step();
        bus16.in_valid = 1'b0;
        check_output("u16_sh_amt_5", 32'(sh_amt16), 32'd5);
        step();
        check_output("u16_result_amt5", 32'(bus16.out_data), 32'h1E00);

        // WIDTH=32 backpressure: park one result, then fill the FIFO
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_data   = 32'h0000_0001;
        bus32.in_amt    = 8'd4;
        step();
        bus32.in_valid = 1'b0;
        step();
        check_output("bp_first_valid", 32'(bus32.out_valid), 32'd1);
        check_output("bp_first_data", bus32.out_data, 32'h10);
        check_output("bp_first_level", 32'(level32), 32'd0);
        stim_data = '{32'h0000_0011, 32'h0000_0100, 32'hF000_000F, 32'h0000_0001};
        stim_amt  = '{8'd1, 8'd8, 8'd4, 8'd31};
        for (int k = 0; k < 4; k++) begin
            bus32.in_valid = 1'b1;
            bus32.in_data  = stim_data[k];
            bus32.in_amt   = stim_amt[k];
            check_output($sformatf("bp_in_ready_push%0d", k), 32'(bus32.in_ready), 32'd1);
            step();
            check_output($sformatf("bp_level_push%0d", k), 32'(level32), 32'(k + 1));
        end
        stim_data.delete();
        stim_amt.delete();
        check_output("bp_in_ready_full", 32'(bus32.in_ready), 32'd0);
        bus32.in_data = 32'hFFFF_FFFF;
        bus32.in_amt  = 8'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_output("bp_full_level", 32'(level32), 32'd4);
            check_output("bp_full_in_ready", 32'(bus32.in_ready), 32'd0);
            check_output("bp_hold_valid", 32'(bus32.out_valid), 32'd1);
            check_output("bp_hold_data", bus32.out_data, 32'h10);
        end
        bus32.in_valid = 1'b0;

        // Drain: parked result then the four queued ones, rejected one absent
        exp_res = '{32'h0000_0010, 32'h0000_0022, 32'h0001_0000, 32'h0000_00F0, 32'h8000_0000};
        apply_stimulus("drain", 30);
        step();
        check_output("drain_no_extra", 32'(bus32.out_valid), 32'd0);
        check_output("drain_level", 32'(level32), 32'd0);

        // Throughput: amounts 1..16 streamed back-to-back from the vector table
        for (int i = 0; i < 16; i++) begin
            stim_data.push_back(vecs[i].data);
            stim_amt.push_back(vecs[i].amt);
            exp_res.push_back(vecs[i].expected);
        end
        apply_stimulus("stream", 60);

        // Reset mid-stream with three queued and one result waiting
        bus32.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus32.in_valid = 1'b1;
            bus32.in_data  = 32'h0000_0001;
            bus32.in_amt   = 8'(k + 1);
            step();
        end
        bus32.in_valid = 1'b0;
        check_output("pre_rst_level", 32'(level32), 32'd3);
        check_output("pre_rst_valid", 32'(bus32.out_valid), 32'd1);
        check_output("pre_rst_data", bus32.out_data, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(bus32.out_valid), 32'd0);
        check_output("mid_rst_level", 32'(level32), 32'd0);
        check_output("mid_rst_in_ready", 32'(bus32.in_ready), 32'd1);
        check_output("mid_rst_sh_data", sh_data32, 32'd0);
        step();
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        check_output("rel_in_ready", 32'(bus32.in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("no_stale_valid", 32'(bus32.out_valid), 32'd0);
            check_output("no_stale_level", 32'(level32), 32'd0);
        end
        stim_data.push_back(32'h0000_0003);
        stim_amt.push_back(8'd2);
        exp_res.push_back(32'h0000_000C);
        apply_stimulus("post_rst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/barrel_shift_issue.md
BARREL_SHIFT_ISSUE -- requirements
Module: barrel_shift_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values 8, 16, 32.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  command offered.
REQ-006 SHALL have port in_ready  output  1  command accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_data  input  WIDTH  operand to shift.
REQ-008 SHALL have port in_amt  input  8  shift amount, unsigned.
REQ-009 SHALL have port sh_data  output  WIDTH  operand driven to the downstream combinational shifter.
REQ-010 SHALL have port sh_amt  output  8  amount driven to the shifter.
REQ-011 SHALL have port sh_result  input  WIDTH  combinational shifter result for the current sh_data/sh_amt.
REQ-012 SHALL have port out_valid  output  1  registered result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_data  output  WIDTH  registered shift result.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL push {in_data, in_amt} into the FIFO on a rising edge where in_valid && in_ready.
REQ-017 SHALL drive in_ready = (level != DEPTH); a pop in the same cycle SHALL NOT raise in_ready while the FIFO is full.
REQ-018 SHALL drive sh_data/sh_amt combinationally from the FIFO head; they SHALL be 0 when the FIFO is empty.
REQ-019 SHALL define issue = (level != 0) && (!out_valid || out_ready).
REQ-020 On issue, SHALL pop the head and capture sh_result into out_data, setting out_valid on the same edge.
REQ-021 SHALL clear out_valid on an edge where out_valid && out_ready && !issue; SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-022 Latency: a command accepted into an empty FIFO with out_valid low at edge E SHALL produce out_valid high after edge E+1.
REQ-023 Throughput: with out_ready held high and in_valid continuously asserted, SHALL deliver one result per cycle after the initial latency.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 Results SHALL emerge in command order with no loss or duplication.
REQ-026 in_valid while in_ready is low SHALL have no effect.

Reset
REQ-027 On rst_n low, SHALL asynchronously clear the FIFO pointers and level to 0, out_valid to 0 and out_data to 0.
REQ-028 Commands in flight when rst_n asserts SHALL be discarded.
REQ-029 in_ready SHALL be 1 during reset and immediately after reset release.

Configuration
REQ-030 With macro BSHIFT_AMT_WRAP_EN defined, sh_amt SHALL equal the head amount modulo WIDTH.
REQ-031 Without BSHIFT_AMT_WRAP_EN, sh_amt SHALL equal the stored amount unchanged.
REQ-032 The macro SHALL NOT change the port list or the timing behaviour.

Verification
REQ-033 WIDTH=8, out_ready=1; push 8'h23 with amt 3 on an empty FIFO -> out_valid high exactly two edges later, out_data equal to the reference-model result for (8'h23, 3).
REQ-034 WIDTH=32, DEPTH=4, out_ready=0; push 5 commands back-to-back -> in_ready falls after the 4th push, level=4, the 5th command is not accepted, and out_valid holds its first result stable.
REQ-035 Release out_ready=1 with in_valid asserted for amts 1..16 -> 16 results in order, one per cycle, with no gaps after the first.
REQ-036 WIDTH=16, amt=20 -> with BSHIFT_AMT_WRAP_EN, sh_amt=4; without it, sh_amt=20.
REQ-037 Assert rst_n low mid-stream with level=3 and out_valid=1 -> out_valid=0, level=0 and in_ready=1 immediately, and no stale result appears after reset release.
